// File: rtl/ipb_slave_regfile.sv
// ipb_slave_regfile: IPbus slave exposing N_REG 32-bit read/write registers
// starting at word address ADDR_BASE. Each transaction takes two cycles:
// the access is performed on the accepting edge and the response (ack/err
// plus read data) is presented for exactly one cycle afterwards.
// Optional feature macro: IPB_SLAVE_ERR_EN -- when defined, out-of-range
// accesses complete with ipb_err; when undefined, they complete with
// ipb_ack, writes are dropped, reads return zero and ipb_err is tied low.
module ipb_slave_regfile #(
    parameter int          N_REG       = 16,
    parameter logic [31:0] REG_RST_VAL = 32'h0000_0000,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic                 ipb_clk,
    input  logic                 ipb_rst,
    input  logic                 ipb_strobe,
    input  logic                 ipb_write,
    input  logic [31:0]          ipb_addr,
    input  logic [31:0]          ipb_wdata,
    output logic [31:0]          ipb_rdata,
    output logic                 ipb_ack,
    output logic                 ipb_err,
    output logic [N_REG*32-1:0]  regs_out,
    output logic [15:0]          txn_cnt
);

    localparam int IDX_W = $clog2(N_REG);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_p1;
    logic [31:0] regs_p1 [N_REG];
    logic        ack_p1;
    logic [31:0] rdata_p1;
    logic [15:0] txn_cnt_p1;
`ifdef IPB_SLAVE_ERR_EN
    logic        err_p1;
`endif

    // Address decode (stage p0): 33-bit arithmetic so neither the offset
    // nor the upper bound can wrap around the 32-bit address space.
    logic [32:0]      addr_off_p0;
    logic             in_range_p0;
    logic [IDX_W-1:0] idx_p0;

    assign addr_off_p0 = {1'b0, ipb_addr} - {1'b0, ADDR_BASE};
    assign in_range_p0 = ({1'b0, ipb_addr} >= {1'b0, ADDR_BASE}) &&
                         (addr_off_p0 < 33'(N_REG));
    assign idx_p0      = addr_off_p0[IDX_W-1:0];

    // Transaction FSM (stage p1): accept in IDLE, perform the access on the
    // accepting edge, present the response for the single RESP cycle.
    always_ff @(posedge ipb_clk) begin
        if (ipb_rst) begin
            state_p1   <= IDLE;
            ack_p1     <= 1'b0;
            rdata_p1   <= 32'h0;
            txn_cnt_p1 <= 16'h0;
            for (int k = 0; k < N_REG; k++) begin
                regs_p1[k] <= REG_RST_VAL;
            end
`ifdef IPB_SLAVE_ERR_EN
            err_p1     <= 1'b0;
`endif
        end else begin
            case (state_p1)
                IDLE: begin
                    ack_p1   <= 1'b0;
                    rdata_p1 <= 32'h0;
`ifdef IPB_SLAVE_ERR_EN
                    err_p1   <= 1'b0;
`endif
                    if (ipb_strobe) begin
                        state_p1 <= RESP;
                        if (in_range_p0) begin
                            ack_p1 <= 1'b1;
                            if (ipb_write) begin
                                regs_p1[idx_p0] <= ipb_wdata;
                            end else begin
                                rdata_p1 <= regs_p1[idx_p0];
                            end
                        end else begin
`ifdef IPB_SLAVE_ERR_EN
                            err_p1 <= 1'b1;
`else
                            ack_p1 <= 1'b1;
`endif
                        end
                    end
                end
                RESP: begin
                    // Response always completes; a strobe seen here is ignored.
                    state_p1   <= IDLE;
                    ack_p1     <= 1'b0;
                    rdata_p1   <= 32'h0;
                    txn_cnt_p1 <= txn_cnt_p1 + 16'd1;
`ifdef IPB_SLAVE_ERR_EN
                    err_p1     <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign ipb_ack   = ack_p1;
    assign ipb_rdata = rdata_p1;
    assign txn_cnt   = txn_cnt_p1;
`ifdef IPB_SLAVE_ERR_EN
    assign ipb_err   = err_p1;
`else
    assign ipb_err   = 1'b0;
`endif

    // Flatten the register array onto the live-contents bus.
    for (genvar k = 0; k < N_REG; k++) begin : g_regs_out
        assign regs_out[32*k +: 32] = regs_p1[k];
    end

endmodule
